cmd_sequencer: RTL

Command-level controller that sits between the UART command receiver (16-bit cmd / cmd_rdy / clr_cmd_rdy handshake) and the execution datapath.
- Consumes one 16-bit command at a time, decodes the opcode and rejects illegal opcodes.
- Dispatches legal commands with a strt/done handshake and supervises execution with a timeout.
- Returns a one-byte ACK or NAK through the UART transmitter (trmt/tx_done handshake).
- Exactly one command is in flight; later commands wait in the receiver until the sequencer returns to IDLE.

---
 rtl/cmd_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cmd_sequencer.sv
// Command sequencer: accepts one UART command at a time, dispatches legal opcodes to the
// datapath under a timeout, and answers each command with an ACK or NAK byte.
module cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned TO_W        = 20,
   parameter logic [15:0] VALID_OPS   = 16'h00FF,
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter logic [7:0]  NAK_BYTE    = 8'h5A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_rdy,
   input  logic [15:0] cmd,
   output logic        clr_cmd_rdy,
   output logic        strt,
   output logic [3:0]  op_code,
   output logic [11:0] op_arg,
   input  logic        done,
   output logic        abort,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DISPATCH  = 3'd1,
      WAIT_DONE = 3'd2,
      RESPOND   = 3'd3,
      WAIT_TX   = 3'd4
   } state_t;

   localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t            state, state_next;
   logic [TO_W-1:0]   timer, timer_next;
   logic [3:0]        op_code_next;
   logic [11:0]       op_arg_next;
   logic [7:0]        tx_data_next;
   logic [7:0]        err_cnt_next;
   logic              nak;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         timer   <= '0;
         op_code <= '0;
         op_arg  <= '0;
         tx_data <= '0;
         err_cnt <= '0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         op_code <= op_code_next;
         op_arg  <= op_arg_next;
         tx_data <= tx_data_next;
         err_cnt <= err_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      timer_next   = timer;
      op_code_next = op_code;
      op_arg_next  = op_arg;
      tx_data_next = tx_data;
      err_cnt_next = err_cnt;
      clr_cmd_rdy  = 1'b0;
      strt         = 1'b0;
      abort        = 1'b0;
      trmt         = 1'b0;
      busy         = 1'b1;
      nak          = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (cmd_rdy) begin
               // Gated so a pending command is not consumed while reset is held
               clr_cmd_rdy  = rst_n;
               op_code_next = cmd[15:12];
               op_arg_next  = cmd[11:0];
               state_next   = DISPATCH;
            end
         end
         DISPATCH: begin
            if (VALID_OPS[op_code]) begin
               strt       = 1'b1;
               timer_next = '0;
               state_next = WAIT_DONE;
            end else begin
               tx_data_next = NAK_BYTE;
               nak          = 1'b1;
               state_next   = RESPOND;
            end
         end
         WAIT_DONE: begin
            timer_next = timer + 1'b1;
            // A completion arriving on the final cycle still counts as success
            if (done) begin
               tx_data_next = ACK_BYTE;
               state_next   = RESPOND;
            end else if (timer == TIMER_LAST) begin
               abort        = 1'b1;
               tx_data_next = NAK_BYTE;
               nak          = 1'b1;
               state_next   = RESPOND;
            end
         end
         RESPOND: begin
            trmt       = 1'b1;
            state_next = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (nak && (err_cnt != 8'hFF)) err_cnt_next = err_cnt + 8'd1;
   end

endmodule
